// File: rtl/radioberry_pkg.sv
// Shared constants and FSM state type for the frequency-to-phase path.
// Build option FREQ_CLAMP_EN limits requested frequencies to the Nyquist rate.
package radioberry_pkg;

  localparam logic [31:0] M2_PHASE   = 32'd1876499845;
  localparam logic [31:0] M3_ROUND   = 32'd16777216;
  localparam logic [31:0] F_NYQ_HZ   = 32'd38400000;
  localparam int          NR_DEFAULT = 3;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    WRITE
  } state_t;

  // With the clamp built in, anything above Nyquist is pinned to Nyquist;
  // otherwise the value passes through and aliases via the phase wrap.
  function automatic logic [31:0] clampFreq(input logic [31:0] f);
`ifdef FREQ_CLAMP_EN
    return (f > F_NYQ_HZ) ? F_NYQ_HZ : f;
`else
    return f;
`endif
  endfunction

endpackage

// File: rtl/seq_mult32.sv
// 32x32 LSB-first shift-add multiplier with accumulator preload.
// Emits a W-bit slice of the 64-bit product starting at bit LO.
module seq_mult32 #(
  parameter int LO = 25,
  parameter int W  = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [31:0]   multiplier,
  input  logic [31:0]   multiplicand,
  input  logic [31:0]   preload,
  output logic [W-1:0]  result,
  output logic          done
);

  logic [31:0] r_bits;
  logic [63:0] r_addend;
  logic [63:0] r_acc;
  logic [4:0]  r_cnt;
  logic        r_run;
  logic        r_done;

  // One multiplier bit per cycle; done pulses on the cycle after the 32nd bit.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bits   <= '0;
      r_addend <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_bits   <= multiplier;
        r_addend <= {32'd0, multiplicand};
        r_acc    <= {32'd0, preload};
        r_cnt    <= '0;
        r_run    <= 1'b1;
      end else if (r_run) begin
        if (r_bits[0]) begin
          r_acc <= r_acc + r_addend;
        end
        r_bits   <= r_bits >> 1;
        r_addend <= r_addend << 1;
        r_cnt    <= r_cnt + 5'd1;
        if (r_cnt == 5'd31) begin
          r_run  <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign result = r_acc[LO+W-1:LO];
  assign done   = r_done;

endmodule

// File: rtl/freq_phase_calc.sv
// Converts per-channel frequency requests (Hz) into registered NCO phase words
// using one shared sequential multiplier and a one-deep pending slot.
// Build option FREQ_CLAMP_EN clamps requests above 38.4 MHz.
module freq_phase_calc
  import radioberry_pkg::*;
#(
  parameter int NR = NR_DEFAULT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     freq_in,
  input  logic [1:0]      chan_in,
  input  logic            freq_valid,
  output logic [NR*32-1:0] phase_word,
  output logic [NR-1:0]   phase_update,
  output logic            busy
);

  state_t            r_state;
  logic [1:0]        r_chan;
  logic              r_pendValid;
  logic [31:0]       r_pendFreq;
  logic [1:0]        r_pendChan;
  logic [NR*32-1:0]  r_phase;
  logic [NR-1:0]     r_update;

  logic              w_reqOk;
  logic              w_capture;
  logic              w_start;
  logic [31:0]       w_rawFreq;
  logic [31:0]       w_operand;
  logic [1:0]        w_loadChan;
  logic [31:0]       w_result;
  logic              w_multDone;

  assign w_reqOk   = freq_valid && (int'(chan_in) < NR);
  // A request goes straight to the multiplier only when nothing is queued or running.
  assign w_capture = w_reqOk && !((r_state == IDLE) && !r_pendValid);

  always_comb begin
    w_start    = 1'b0;
    w_rawFreq  = r_pendFreq;
    w_loadChan = r_pendChan;
    case (r_state)
      IDLE: begin
        if (r_pendValid) begin
          w_start = 1'b1;
        end else if (w_reqOk) begin
          w_start    = 1'b1;
          w_rawFreq  = freq_in;
          w_loadChan = chan_in;
        end
      end
      WRITE: begin
        if (r_pendValid) begin
          w_start = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  assign w_operand = clampFreq(w_rawFreq);

  seq_mult32 #(.LO(25), .W(32)) u_mult (
    .clock        (clock),
    .reset        (reset),
    .start        (w_start),
    .multiplier   (w_operand),
    .multiplicand (M2_PHASE),
    .preload      (M3_ROUND),
    .result       (w_result),
    .done         (w_multDone)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_chan      <= '0;
      r_pendValid <= 1'b0;
      r_pendFreq  <= '0;
      r_pendChan  <= '0;
      r_phase     <= '0;
      r_update    <= '0;
    end else begin
      r_update <= '0;
      if (w_capture) begin
        r_pendValid <= 1'b1;
        r_pendFreq  <= freq_in;
        r_pendChan  <= chan_in;
      end else if (w_start && r_pendValid) begin
        r_pendValid <= 1'b0;
      end
      if (w_start) begin
        r_chan <= w_loadChan;
      end
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state <= MUL;
          end
        end
        MUL: begin
          if (w_multDone) begin
            for (int n = 0; n < NR; n++) begin
              if (int'(r_chan) == n) begin
                r_phase[n*32 +: 32] <= w_result;
                r_update[n]         <= 1'b1;
              end
            end
            r_state <= WRITE;
          end
        end
        WRITE: begin
          r_state <= w_start ? MUL : IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign phase_word   = r_phase;
  assign phase_update = r_update;
  assign busy         = (r_state != IDLE) || r_pendValid;

endmodule

// File: doc/freq_phase_calc.md
Name: freq_phase_calc

Overview:
- Sits between the SPI command decode and the NR receiver NCOs.
- Converts a 32-bit frequency word in Hz, tagged with a channel index, into a 32-bit NCO phase word: phase = (freq*M2 + M3)[56:25], where M2 = 2^57/76.8 MHz.
- Uses a sequential shift-add multiplier instead of NR parallel 32x32 combinational multipliers.
- Holds one registered phase word per channel.

Parameters:
- NR, 3, number of receiver channels (1..4).
- M2, 32'd1876499845, frequency-to-phase scale constant.
- M3, 32'd16777216, rounding offset (2^24).

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- freq_in  in  32  requested frequency, Hz, unsigned.
- chan_in  in  2  target channel index.
- freq_valid  in  1  single-cycle request strobe; qualifies freq_in and chan_in.
- phase_word  out  NR*32  flattened per-channel phase words; channel n occupies [32n+31:32n].
- phase_update  out  NR  one-cycle pulse per channel when its phase word changes.
- busy  out  1  high while a multiply is in progress or a request is pending.

Behaviour:
- Reset:
  - phase_word = 0 for all channels; phase_update = 0; busy = 0.
  - State machine returns to IDLE; pending slot cleared.
  - Reset asserted mid-multiply aborts the operation with no output write.
- States:
  - IDLE: on freq_valid with chan_in < NR, latch multiplicand = freq_in, channel = chan_in; accumulator = M3; go to MUL.
  - MUL: 32 cycles, one multiplier bit per cycle, LSB first. If the current bit is 1, add M2 << k into a 64-bit accumulator. After 32 cycles go to WRITE.
  - WRITE: phase_word[channel] <= acc[56:25]; pulse phase_update[channel] for one cycle. Then:
    - If the pending slot is valid, load it and go to MUL (no IDLE cycle).
    - Otherwise go to IDLE.
- Latency: freq_valid in cycle t → phase_word updated and phase_update high in cycle t+34. Back-to-back through pending: 34 cycles per request.
- Pending slot (one deep):
  - freq_valid arriving while not IDLE writes the slot.
  - A later request overwrites an earlier pending one (latest wins).
  - The in-flight operation is never disturbed.
- freq_valid in the same cycle as WRITE: goes to the pending slot and is serviced next.
- chan_in >= NR: request ignored; no state change; busy is unaffected.
- Arithmetic:
  - Unsigned throughout; accumulator is 64 bits wide and cannot overflow (max < 2^63).
  - Result bits above 56 are discarded.
- busy = (state != IDLE) || pending_valid.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: FREQ_CLAMP_EN.
- Defined: when latched, freq_in values above 38_400_000 (Nyquist of 76.8 MHz) are replaced by 38_400_000, applied at both the IDLE load and the pending-slot load.
- Undefined: freq_in is used unmodified; out-of-range values alias per the modulo-2^32 phase wrap.

Decomposition:
- Shared package radioberry_pkg holds:
  - constants M2_PHASE, M3_ROUND, F_NYQ_HZ = 38_400_000, default NR;
  - state enum typedef (IDLE, MUL, WRITE).
- One natural sub-module: seq_mult32.
  - 32x32 shift-add multiplier with start/done and a preload input for M3.
  - freq_phase_calc wraps it with the channel register bank and the pending slot.

Test Plan:
- Reset, then freq_in = 0 on chan 0 → phase_word[0] = 0 at t+34; phase_update[0] pulses once; other channels stay 0.
- freq_in = 7_040_100 on chan 1 → phase_word[1] = (7040100*M2 + 2^24)[56:25] from the reference model, ≈393_710_928; phase_update[1] at exactly t+34.
- Three requests on consecutive cycles (ch0 = 10_140_200, ch1 = 14_097_100, ch2 = 28_126_100) → ch0 computed; ch1 overwritten in the pending slot; only ch0 and ch2 update, at t+34 and t+68; busy falls at t+69.
- chan_in = 3 with NR = 3 → no update, busy stays 0.
- Reset asserted at cycle 20 of MUL → no phase_update; all outputs 0; a new request afterwards completes normally.
- freq_in = 0xFFFFFFFF:
  - with FREQ_CLAMP_EN → result equals that for 38_400_000 (0x80000000 ± 1 LSB);
  - without FREQ_CLAMP_EN → result equals the model's raw [56:25] slice.
